// File: rtl/gray_seq_ctrl.sv
// Sequencer that walks a binary counter up or down from a programmed start value
// and streams each value with its Gray code over a valid/ready handshake.
module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0] seq_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer;

  assign xfer = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = RUN;
          bin_d   = init_val;
          rem_d   = seq_len;
          dir_d   = dir;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // An abort wins even when the final code transfers on the same edge.
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer) begin
          if (rem_q == '0) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            bin_d = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
            rem_d = rem_q - WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // Gray code tracks the next binary value so both outputs update together.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      rem_q   <= '0;
      gray_q  <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      rem_q   <= rem_d;
      gray_q  <= gray_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign gray_out  = gray_q;
  assign bin_out   = bin_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Randomized bench for gray_seq_ctrl: expected codes come from index arithmetic
// modulo 16 plus a literal 4-bit Gray table.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, dir, out_ready;
  logic [3:0] init_val, seq_len;
  logic       out_valid, busy, done;
  logic [3:0] gray_out, bin_out;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] GRAY_TBL [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .init_val(init_val), .seq_len(seq_len), .out_ready(out_ready),
    .out_valid(out_valid), .gray_out(gray_out), .bin_out(bin_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // k-th code of a sequence, as plain modular arithmetic.
  function automatic logic [3:0] code_at(input int init, input int d, input int k);
    int v;
    v = (d != 0) ? init - k : init + k;
    return 4'(((v % 16) + 16) % 16);
  endfunction

  function automatic logic [10:0] exp_word(input logic [3:0] b);
    return {1'b1, 1'b1, 1'b0, b, GRAY_TBL[b]};
  endfunction

  task automatic run_seq(input int init, input int len, input int d, input int ready_pct,
                         input int stop_at, input bit poke, input bit stop_with_start,
                         output int xfers);
    int idx;
    int cycles;
    bit fin;
    logic [10:0] obs;
    logic [10:0] exp;
    xfers = 0;
    @(negedge clk);
    start = 1'b1; stop = stop_with_start; out_ready = 1'b0;
    init_val = 4'(init); seq_len = 4'(len); dir = 1'(d);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    idx = 0; fin = 1'b0; cycles = 0;
    while (!fin && cycles < 200) begin
      obs = {out_valid, busy, done, bin_out, gray_out};
      exp = exp_word(code_at(init, d, idx));
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL run_code idx=%0d actual=%h required=%h", idx, obs, exp);
      end
      out_ready = (int'($urandom_range(0, 99)) < ready_pct);
      if (idx == stop_at) begin
        out_ready = 1'b1;
        stop = 1'b1;
      end
      if (poke) begin
        start = 1'($urandom); init_val = 4'($urandom); seq_len = 4'($urandom); dir = 1'($urandom);
      end
      @(negedge clk);
      cycles++;
      if (stop) begin
        xfers++;
        total++;
        if ({out_valid, busy, done} !== 3'b000) begin
          bad++;
          $display("[TB] FAIL stop_idle actual=%b required=000", {out_valid, busy, done});
        end
        fin = 1'b1;
      end else if (out_ready) begin
        xfers++;
        if (idx == len) begin
          total++;
          if ({out_valid, busy, done} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL done_pulse actual=%b required=011", {out_valid, busy, done});
          end
          @(negedge clk);
          total++;
          if ({out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL after_done actual=%b required=000", {out_valid, busy, done});
          end
          fin = 1'b1;
        end else begin
          idx++;
        end
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("[TB] FAIL seq_timeout actual=%0d cycles required=completion", cycles);
    end
    start = 1'b0; stop = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; out_ready = 1'b0;
    init_val = 4'h0; seq_len = 4'h0;
    #1;
    total++;
    if ({out_valid, busy, done, bin_out, gray_out} !== 11'd0) begin
      bad++;
      $display("[TB] FAIL reset_state actual=%h required=000", {out_valid, busy, done, bin_out, gray_out});
    end
    @(negedge clk);
    rst = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if ({out_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL stop_in_idle actual=%b required=000", {out_valid, busy, done});
    end
  endtask

  task automatic test_full_sweep();
    int n;
    run_seq(0, 15, 0, 100, -1, 1'b0, 1'b0, n);
    total++;
    if (n !== 16) begin
      bad++;
      $display("[TB] FAIL sweep_xfers actual=%0d required=16", n);
    end
  endtask

  task automatic test_wrap();
    int n;
    run_seq(14, 3, 0, 100, -1, 1'b0, 1'b0, n);
    total++;
    if (n !== 4) begin
      bad++;
      $display("[TB] FAIL wrap_up_xfers actual=%0d required=4", n);
    end
    run_seq(1, 2, 1, 100, -1, 1'b0, 1'b0, n);
    total++;
    if (n !== 3) begin
      bad++;
      $display("[TB] FAIL wrap_down_xfers actual=%0d required=3", n);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] seq [5] = '{4'd5, 4'd5, 4'd5, 4'd6, 4'd7};
    @(negedge clk);
    start = 1'b1; init_val = 4'd5; seq_len = 4'd2; dir = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, busy, done, bin_out, gray_out} !== exp_word(seq[i])) begin
        bad++;
        $display("[TB] FAIL backpressure step=%0d actual=%h required=%h", i,
                 {out_valid, busy, done, bin_out, gray_out}, exp_word(seq[i]));
      end
      out_ready = (i >= 2);
      @(negedge clk);
    end
    total++;
    if ({out_valid, busy, done} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL bp_done actual=%b required=011", {out_valid, busy, done});
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stop();
    int n;
    run_seq(9, 7, 0, 100, 2, 1'b1, 1'b0, n);
    total++;
    if (n !== 3) begin
      bad++;
      $display("[TB] FAIL stop_xfers actual=%0d required=3", n);
    end
    run_seq(4, 5, 1, 100, -1, 1'b0, 1'b1, n);
    total++;
    if (n !== 6) begin
      bad++;
      $display("[TB] FAIL start_stop_idle_xfers actual=%0d required=6", n);
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    start = 1'b1; init_val = 4'd0; seq_len = 4'd15; dir = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, done, bin_out, gray_out} !== 11'd0) begin
      bad++;
      $display("[TB] FAIL async_reset actual=%h required=000", {out_valid, busy, done, bin_out, gray_out});
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL post_reset_idle actual=%b required=000", {out_valid, busy, done});
    end
    run_seq(3, 4, 0, 100, -1, 1'b0, 1'b0, n);
  endtask

  task automatic test_random();
    int n;
    int len;
    for (int t = 0; t < 25; t++) begin
      len = int'($urandom_range(0, 15));
      run_seq(int'($urandom_range(0, 15)), len, int'($urandom_range(0, 1)), 60,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1,
              1'b1, 1'($urandom), n);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_wrap();
    test_backpressure();
    test_stop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
